pipe_stall_controller: RTL
==========================

Name: pipe_stall_controller

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined multicycle core (IF/ID/EX/MEM/WB).
- Keeps a register scoreboard of in-flight writes and detects RAW/WAW hazards at ID.
- Holds the pipeline while a multicycle EX operation (mul/div) occupies EX.
- Issues flushes on taken branches resolved in EX.
- Drives the enable, flush and bubble controls of the PC and the pipeline registers.

Parameters:
- NREG, 8, number of architectural registers; r0 is hardwired zero.
- REG_AW, 3, register index width (log2 NREG).
- MC_LAT, 4, cycles a multicycle op occupies EX; legal values 2..15.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  valid instruction in ID.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination index.
- id_wr  in  1  instruction writes rd.
- id_is_mc  in  1  instruction is a multicycle EX op.
- ex_branch_taken  in  1  branch in EX resolved taken.
- wb_valid  in  1  WB stage writing the register file.
- wb_rd  in  REG_AW  WB destination index.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_en  out  1  ID/EX register load enable.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_bubble  out  1  load NOP into EX/MEM.
- issue  out  1  ID instruction advances to EX this cycle.
- mc_busy  out  1  multicycle op occupying EX.
- sb_pending  out  NREG  scoreboard bits.
- stall_cnt  out  CNT_W  stall-cycle counter.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - sb_pending=0, state=IDLE, mc counter=0, stall_cnt=0.
  - Outputs during and after reset: pc_en=1, ifid_en=1, idex_en=1, all flush/bubble signals=0, issue=0, mc_busy=0.
  - Reset asserted mid-MC_BUSY aborts to IDLE in the next cycle.
- Effective scoreboard: sb_eff = sb_pending with bit wb_rd cleared when wb_valid=1 (same-cycle WB bypass).
- hazard = (id_use_rs1 & sb_eff[rs1]) | (id_use_rs2 & sb_eff[rs2]) | (id_wr & sb_eff[rd]).
  - Index 0 never hazards.
- flush = ex_branch_taken & (state==IDLE).
- stall = id_valid & (hazard | state==MC_BUSY) & ~flush.
- issue = id_valid & ~hazard & ~flush & state==IDLE.
- Output priority, all combinational:
  - flush: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1. Flush overrides hazard stall.
  - MC_BUSY: pc_en=0, ifid_en=0, idex_en=0, idex_bubble=0, exmem_bubble=1, except on the final busy cycle (counter==0), where exmem_bubble=0 so the result advances.
  - hazard stall in IDLE: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
  - otherwise: pc_en=ifid_en=idex_en=1, no bubbles.
- FSM, two states:
  - IDLE -> MC_BUSY when issue & id_is_mc; counter loads MC_LAT-1.
  - MC_BUSY: counter decrements each cycle; returns to IDLE on the cycle after counter==0.
  - mc_busy=1 exactly while state==MC_BUSY.
  - Total EX occupancy is MC_LAT cycles; the first cycle is the issue-following cycle.
- ex_branch_taken in MC_BUSY is illegal: it is ignored and flagged with a simulation assertion.
- Scoreboard, clocked:
  - Set bit id_rd when issue & id_wr & id_rd!=0.
  - Clear bit wb_rd when wb_valid.
  - Set and clear of the same index in the same cycle: set wins.
  - Clearing an already-clear bit is harmless.
  - A flushed ID instruction never sets a bit.
- stall_cnt increments each cycle stall=1; saturates at all-ones and holds.

Test Plan:
- Reset held 2 cycles, then id_valid=1 with independent regs → issue=1 every cycle; sb_pending tracks each rd; stall_cnt=0.
- Issue rd=3, then next ID reads rs1=3 with no WB → pc_en=0, idex_bubble=1; wb_valid with wb_rd=3 asserted → same-cycle issue=1, stall_cnt=count of stalled cycles.
- id_is_mc issue with MC_LAT=4 → mc_busy=1 for 4 cycles; exmem_bubble=1, 1, 1, 0; pc_en=0 throughout; IDLE on cycle 5.
- ex_branch_taken concurrent with an ID hazard → ifid_flush=1, idex_bubble=1, pc_en=1, issue=0; scoreboard unchanged.
- Same-cycle issue rd=5 and wb_valid wb_rd=5 → sb_pending[5]=1 afterwards; id_rd=0 with id_wr → bit 0 stays 0.
- reset asserted on busy cycle 2 → next cycle state IDLE, mc_busy=0, sb_pending=0; force 65540 stall cycles → stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_stall_controller.sv
// Hazard and sequencing controller for the 5-stage core: it tracks in-flight register
// writes, holds the pipe while mul/div occupies EX, and flushes on taken branches.
module pipe_stall_controller #(
    parameter int NREG   = 8,
    parameter int REG_AW = 3,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_is_mc,
    input  logic              ex_branch_taken,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              issue,
    output logic              mc_busy,
    output logic [NREG-1:0]   sb_pending,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MC_W = 4;

    typedef enum logic {
        IDLE,
        MC_BUSY
    } state_t;

    state_t            state, state_nxt;
    logic [MC_W-1:0]   mc_cnt, mc_cnt_nxt;
    logic [NREG-1:0]   sb_eff, sb_nxt;
    logic              hazard, flush, stall, issue_raw;

    // A register written back this very cycle is already readable, so its bit is masked.
    always_comb begin
        sb_eff = sb_pending;
        if (wb_valid) begin
            sb_eff[wb_rd] = 1'b0;
        end
        sb_eff[0] = 1'b0;
    end

    assign hazard    = (id_use_rs1 & sb_eff[id_rs1]) |
                       (id_use_rs2 & sb_eff[id_rs2]) |
                       (id_wr      & sb_eff[id_rd]);
    assign flush     = ex_branch_taken & (state == IDLE);
    assign stall     = id_valid & (hazard | (state == MC_BUSY)) & ~flush;
    assign issue_raw = id_valid & ~hazard & ~flush & (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mc_cnt     <= '0;
            sb_pending <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            mc_cnt     <= mc_cnt_nxt;
            sb_pending <= sb_nxt;
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Set is applied after clear so an issue and a writeback to the same register keep it pending.
    always_comb begin
        sb_nxt = sb_pending;
        if (wb_valid) begin
            sb_nxt[wb_rd] = 1'b0;
        end
        if (issue_raw && id_wr && (id_rd != '0)) begin
            sb_nxt[id_rd] = 1'b1;
        end
        sb_nxt[0] = 1'b0;
    end

    always_comb begin
        state_nxt    = state;
        mc_cnt_nxt   = mc_cnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        issue        = 1'b0;
        mc_busy      = 1'b0;

        case (state)
            IDLE: begin
                if (issue_raw && id_is_mc) begin
                    state_nxt  = MC_BUSY;
                    mc_cnt_nxt = MC_W'(MC_LAT - 1);
                end
            end
            MC_BUSY: begin
                if (mc_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    mc_cnt_nxt = mc_cnt - MC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset forces the free-running defaults regardless of the stale state.
        if (!reset) begin
            issue   = issue_raw;
            mc_busy = (state == MC_BUSY);
            if (flush) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (state == MC_BUSY) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = (mc_cnt != '0);
            end else if (id_valid && hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    no_branch_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(ex_branch_taken && (state == MC_BUSY)));

endmodule
